vga_pixel_write_port: RTL and testbench
=======================================

Name: vga_pixel_write_port

Overview:
Downstream stage of the motor-signals-to-VGA logic. Consumes its per-pixel write stream (wr_en, wr_x, wr_y, byte_out) and turns it into linear-address writes on the frame-buffer RAM write port.
- Filters off-screen coordinates (the pen position starts at row VGA_ROWS, i.e. off-screen).
- Suppresses repeated identical writes.
- Buffers writes in a small FIFO so the RAM port may stall via mem_ready.

Parameters:
COLS, `VGA_COLUMNS, visible columns; x valid iff x < COLS
ROWS, `VGA_ROWS, visible rows; y valid iff y < ROWS
FIFO_DEPTH, 4, write-FIFO entries (power of two, >= 2)
ADDR_BITS, $clog2(COLS*ROWS), frame-buffer address width
CNT_BITS, 16, width of diagnostic counters

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
clk_en  in  1  input-sampling enable (same enable as upstream stage)
in_wr_en  in  1  upstream write request
in_x  in  `VGA_H_BITS  upstream column
in_y  in  `VGA_V_BITS  upstream row
in_byte  in  `BYTE_BITS  pixel value
mem_ready  in  1  RAM write port accepts this cycle
mem_wr_en  out  1  head entry valid (write request)
mem_addr  out  ADDR_BITS  y*COLS + x of head entry
mem_data  out  `BYTE_BITS  pixel value of head entry
drop_count  out  CNT_BITS  out-of-range writes discarded, saturating
overflow_count  out  CNT_BITS  writes lost to full FIFO, saturating

Behaviour:
- Reset: mem_wr_en=0, mem_addr=0, mem_data=0, drop_count=0, overflow_count=0; FIFO empty, pipe register invalid, dedup key invalid.
- Reset mid-operation discards all queued entries; there is no partial write.

Sampling (stage 0):
- Acts only on clk edges where clk_en & in_wr_en.
- If in_x >= COLS or in_y >= ROWS: discard and increment drop_count (saturates at all-ones). The dedup key is unchanged.
- Else if the dedup key is valid and {in_x, in_y, in_byte} equals it: discard silently, no counter change.
- Else: load the pipe register with {addr = in_y*COLS + in_x, in_byte}, set it valid, and update the dedup key.
- Address product is computed at full width, then truncated to ADDR_BITS; in range by construction.

Stage 1 (every clk, independent of clk_en):
- A valid pipe register is pushed into the FIFO, then the pipe register is invalidated unless reloaded the same edge.
- Push is allowed if the FIFO is not full, or if a pop occurs on the same edge.
- If the push is refused: entry lost, overflow_count increments (saturating), and the dedup key is invalidated so a retry of the same pixel is not suppressed.

Memory side:
- mem_wr_en = FIFO not empty; mem_addr and mem_data show the head entry.
- Transfer occurs on edges where mem_wr_en & mem_ready; the head pops.
- mem_addr and mem_data stay stable while mem_wr_en=1 and mem_ready=0.

Latency and throughput:
- Accepted sample at edge N → pushed at edge N+1 → mem_wr_en high during cycle after N+1, if the FIFO was empty.
- Sustains one write per clk when mem_ready stays high.

Simultaneous events:
- Push+pop when full: both occur, occupancy unchanged.
- Push+pop when empty: the entry is pushed; no pop that edge, since there is no head yet.
- Drop and overflow on the same edge: both counters increment.

Decomposition:
- Shared vga package: VGA_COLUMNS/VGA_ROWS use, the pixel write-entry struct {addr, data}, and the counter saturation max constant.
- One sub-module: vga_write_fifo, a single-clock synchronous FIFO with push/pop/full/empty and first-word-fall-through head. The top holds the pipe register, bounds check, dedup and counters.

Test Plan:
(Bench overrides: COLS=8, ROWS=6, FIFO_DEPTH=4, mem_ready=1, clk_en=1 unless stated.)
1. Write x=3, y=2, byte=0xFF → exactly one mem_wr_en pulse, 2 cycles later, mem_addr=19, mem_data=0xFF.
2. Write x=0, y=6 (pen reset position), then x=8, y=0 → no mem_wr_en; drop_count=2.
3. Same (3,2,0xFF) on three consecutive cycles, then (3,2,0x15) → two RAM writes: addr 19 with 0xFF, then addr 19 with 0x15.
4. mem_ready=0; six distinct in-range writes on consecutive cycles → FIFO holds first 4, overflow_count=2, mem_addr frozen on first entry. Raise mem_ready → exactly 4 writes in order.
5. FIFO full and mem_ready=1; new write arrives on the same edge as a pop → accepted, overflow_count unchanged, occupancy stays 4.
6. Reset asserted while 3 entries are queued → next cycle mem_wr_en=0 and counters=0; a subsequent write of the previous pixel is not dedup-suppressed.

Source files
------------

// File: rtl/vga_pixel_write_port_pkg.sv
// Shared VGA constants and frame-buffer write-entry type for the pixel write port.
package vga_pixel_write_port_pkg;

    localparam int unsigned VGA_COLUMNS      = 640;
    localparam int unsigned VGA_ROWS         = 480;
    localparam int unsigned VGA_H_BITS       = 10;
    localparam int unsigned VGA_V_BITS       = 9;
    localparam int unsigned BYTE_BITS        = 8;
    localparam int unsigned VGA_ADDR_BITS    = $clog2(VGA_COLUMNS * VGA_ROWS);
    localparam int unsigned CNT_BITS_DEFAULT = 16;

    // Sized for the full-resolution frame; smaller frames use the low address bits.
    typedef struct packed {
        logic [VGA_ADDR_BITS-1:0] addr;
        logic [BYTE_BITS-1:0]     data;
    } pix_entry_t;

endpackage

// File: rtl/vga_pixel_write_port_if.sv
// Frame-buffer RAM write port: request with address/data, stalled by mem_ready.
interface vga_pixel_write_port_if #(
    parameter int unsigned ADDR_BITS = vga_pixel_write_port_pkg::VGA_ADDR_BITS
);
    import vga_pixel_write_port_pkg::*;

    logic                 mem_wr_en;
    logic [ADDR_BITS-1:0] mem_addr;
    logic [BYTE_BITS-1:0] mem_data;
    logic                 mem_ready;

    modport master (
        output mem_wr_en,
        output mem_addr,
        output mem_data,
        input  mem_ready
    );

    modport slave (
        input  mem_wr_en,
        input  mem_addr,
        input  mem_data,
        output mem_ready
    );

endinterface

// File: rtl/vga_write_fifo.sv
// Single-clock synchronous FIFO with first-word-fall-through head.
module vga_write_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);
    localparam int unsigned PTR_BITS = $clog2(DEPTH);

    logic [WIDTH-1:0]  r_mem [DEPTH];
    logic [PTR_BITS:0] r_wptr;
    logic [PTR_BITS:0] r_rptr;

    // Extra pointer bit separates full from empty when the slot indices match.
    assign o_empty = (r_wptr == r_rptr);
    assign o_full  = (r_wptr[PTR_BITS] != r_rptr[PTR_BITS]) &&
                     (r_wptr[PTR_BITS-1:0] == r_rptr[PTR_BITS-1:0]);
    assign o_data  = r_mem[r_rptr[PTR_BITS-1:0]];

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (i_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (i_pop && !o_empty) begin
                r_rptr <= r_rptr + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_push) begin
            r_mem[r_wptr[PTR_BITS-1:0]] <= i_data;
        end
    end

endmodule

// File: rtl/vga_pixel_write_port.sv
// Turns the upstream per-pixel write stream into buffered linear frame-buffer writes.
module vga_pixel_write_port
    import vga_pixel_write_port_pkg::*;
#(
    parameter int unsigned COLS       = VGA_COLUMNS,
    parameter int unsigned ROWS       = VGA_ROWS,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned ADDR_BITS  = $clog2(COLS * ROWS),
    parameter int unsigned CNT_BITS   = CNT_BITS_DEFAULT
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_clk_en,
    input  logic                   i_wr_en,
    input  logic [VGA_H_BITS-1:0]  i_x,
    input  logic [VGA_V_BITS-1:0]  i_y,
    input  logic [BYTE_BITS-1:0]   i_byte,
    vga_pixel_write_port_if.master mem_if,
    output logic [CNT_BITS-1:0]    o_drop_count,
    output logic [CNT_BITS-1:0]    o_overflow_count
);
    localparam logic [CNT_BITS-1:0] CNT_MAX = {CNT_BITS{1'b1}};

    pix_entry_t            r_pipe;
    logic                  r_pipe_vld;
    logic                  r_key_vld;
    logic [VGA_H_BITS-1:0] r_key_x;
    logic [VGA_V_BITS-1:0] r_key_y;
    logic [BYTE_BITS-1:0]  r_key_byte;
    logic [CNT_BITS-1:0]   r_drop_cnt;
    logic [CNT_BITS-1:0]   r_ovf_cnt;

    logic       w_sample, w_in_range, w_dup, w_drop, w_accept;
    logic       w_full, w_empty, w_push, w_pop, w_overflow;
    logic       w_unused_head;
    pix_entry_t w_new;
    pix_entry_t w_head;

    assign w_sample   = i_clk_en & i_wr_en;
    assign w_in_range = (32'(i_x) < COLS) && (32'(i_y) < ROWS);
    assign w_dup      = r_key_vld && ({i_x, i_y, i_byte} == {r_key_x, r_key_y, r_key_byte});
    assign w_drop     = w_sample & ~w_in_range;
    assign w_accept   = w_sample & w_in_range & ~w_dup;
    assign w_new      = '{addr: VGA_ADDR_BITS'(32'(i_y) * COLS + 32'(i_x)), data: i_byte};

    // A pop frees a slot on the same edge, so a full FIFO can still take the pipe entry.
    assign w_pop      = ~w_empty & mem_if.mem_ready;
    assign w_push     = r_pipe_vld & (~w_full | w_pop);
    assign w_overflow = r_pipe_vld & ~w_push;

    vga_write_fifo #(
        .WIDTH ($bits(pix_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_push  (w_push),
        .i_data  (r_pipe),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign mem_if.mem_wr_en = ~w_empty;
    assign mem_if.mem_addr  = w_empty ? '0 : w_head.addr[ADDR_BITS-1:0];
    assign mem_if.mem_data  = w_empty ? '0 : w_head.data;
    assign w_unused_head    = ^w_head.addr;
    assign o_drop_count     = r_drop_cnt;
    assign o_overflow_count = r_ovf_cnt;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pipe     <= '0;
            r_pipe_vld <= 1'b0;
            r_key_vld  <= 1'b0;
            r_key_x    <= '0;
            r_key_y    <= '0;
            r_key_byte <= '0;
            r_drop_cnt <= '0;
            r_ovf_cnt  <= '0;
        end else begin
            r_pipe_vld <= w_accept;
            if (w_accept) begin
                r_pipe     <= w_new;
                r_key_vld  <= 1'b1;
                r_key_x    <= i_x;
                r_key_y    <= i_y;
                r_key_byte <= i_byte;
            end else if (w_overflow) begin
                // Lost entry must not suppress a retry of the same pixel.
                r_key_vld <= 1'b0;
            end
            if (w_drop && r_drop_cnt != CNT_MAX) begin
                r_drop_cnt <= r_drop_cnt + 1'b1;
            end
            if (w_overflow && r_ovf_cnt != CNT_MAX) begin
                r_ovf_cnt <= r_ovf_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_vga_pixel_write_port.sv
// Scoreboard bench: a behavioural model predicts RAM writes and counters; a monitor compares.
module tb_vga_pixel_write_port;
    import vga_pixel_write_port_pkg::*;

    localparam int unsigned COLS  = 8;
    localparam int unsigned ROWS  = 6;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned ABITS = $clog2(COLS * ROWS);
    localparam int unsigned CBITS = 16;

    typedef struct {
        int unsigned addr;
        int unsigned data;
    } wr_t;

    logic                  clk    = 1'b0;
    logic                  reset  = 1'b1;
    logic                  clk_en = 1'b1;
    logic                  wr_en  = 1'b0;
    logic [VGA_H_BITS-1:0] x      = '0;
    logic [VGA_V_BITS-1:0] y      = '0;
    logic [BYTE_BITS-1:0]  pix    = '0;
    logic [CBITS-1:0]      drop_count;
    logic [CBITS-1:0]      overflow_count;

    int errors   = 0;
    int checks   = 0;
    int n_writes = 0;

    // Reference model state
    wr_t         exp_q[$];
    int unsigned m_occ  = 0;
    int unsigned m_drop = 0;
    int unsigned m_ovf  = 0;
    bit          m_pipe_v = 0;
    wr_t         m_pipe;
    bit          m_key_v = 0;
    int unsigned m_key_x, m_key_y, m_key_b;

    vga_pixel_write_port_if #(.ADDR_BITS(ABITS)) mif();

    vga_pixel_write_port #(
        .COLS       (COLS),
        .ROWS       (ROWS),
        .FIFO_DEPTH (DEPTH),
        .ADDR_BITS  (ABITS),
        .CNT_BITS   (CBITS)
    ) dut (
        .i_clk            (clk),
        .i_reset          (reset),
        .i_clk_en         (clk_en),
        .i_wr_en          (wr_en),
        .i_x              (x),
        .i_y              (y),
        .i_byte           (pix),
        .mem_if           (mif),
        .o_drop_count     (drop_count),
        .o_overflow_count (overflow_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Behavioural model: one queue of pending RAM writes plus an occupancy count.
    always @(posedge clk) begin : model
        bit pop, lost, acc;
        if (reset) begin
            m_occ = 0; m_drop = 0; m_ovf = 0; m_pipe_v = 0; m_key_v = 0;
            exp_q.delete();
        end else begin
            pop  = (m_occ > 0) && (mif.mem_ready === 1'b1);
            lost = 0;
            acc  = 0;
            if (m_pipe_v) begin
                if (m_occ < DEPTH || pop) begin
                    exp_q.push_back(m_pipe);
                    m_occ++;
                end else begin
                    lost = 1;
                    if (m_ovf < 32'hFFFF) m_ovf++;
                end
            end
            if (pop) m_occ--;
            m_pipe_v = 0;
            if (clk_en && wr_en) begin
                if (int'(x) >= COLS || int'(y) >= ROWS) begin
                    if (m_drop < 32'hFFFF) m_drop++;
                end else if (!(m_key_v && m_key_x == x && m_key_y == y && m_key_b == pix)) begin
                    m_pipe.addr = int'(y) * COLS + int'(x);
                    m_pipe.data = int'(pix);
                    m_pipe_v = 1;
                    m_key_v = 1; m_key_x = x; m_key_y = y; m_key_b = pix;
                    acc = 1;
                end
            end
            if (lost && !acc) m_key_v = 0;
        end
    end

    // Monitor: compares the RAM port and counters against the model on each falling edge.
    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            chk("mem_wr_en", 32'(mif.mem_wr_en), 32'(m_occ > 0));
            if (mif.mem_wr_en === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got addr %0d data %0h, required no write",
                             mif.mem_addr, mif.mem_data);
                end else begin
                    chk("mem_addr", 32'(mif.mem_addr), exp_q[0].addr);
                    chk("mem_data", 32'(mif.mem_data), exp_q[0].data);
                    if (mif.mem_ready === 1'b1) begin
                        void'(exp_q.pop_front());
                        n_writes++;
                    end
                end
            end
            chk("drop_count", 32'(drop_count), m_drop);
            chk("overflow_count", 32'(overflow_count), m_ovf);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic put(input int unsigned px, input int unsigned py, input int unsigned pb);
        wr_en = 1'b1;
        x     = VGA_H_BITS'(px);
        y     = VGA_V_BITS'(py);
        pix   = BYTE_BITS'(pb);
        step();
        wr_en = 1'b0;
    endtask

    task automatic do_reset();
        wr_en = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic drain();
        int k = 0;
        mif.mem_ready = 1'b1;
        while ((m_occ > 0 || m_pipe_v) && k < 60) begin
            step();
            k++;
        end
        idle(1);
        chk("drain_done", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int n0;
        mif.mem_ready = 1'b1;
        idle(2);
        reset = 1'b0;

        // Single in-range write and its latency
        n0 = n_writes;
        put(3, 2, 8'hFF);
        chk("t1_not_yet", 32'(mif.mem_wr_en), 32'd0);
        step();
        chk("t1_wr_en", 32'(mif.mem_wr_en), 32'd1);
        chk("t1_addr", 32'(mif.mem_addr), 32'd19);
        chk("t1_data", 32'(mif.mem_data), 32'hFF);
        idle(3);
        chk("t1_writes", 32'(n_writes - n0), 32'd1);

        // Off-screen writes are dropped
        do_reset();
        n0 = n_writes;
        put(0, 6, 8'h01);
        put(8, 0, 8'h02);
        idle(3);
        chk("t2_writes", 32'(n_writes - n0), 32'd0);
        chk("t2_drop", 32'(drop_count), 32'd2);

        // Repeated identical writes collapse
        do_reset();
        n0 = n_writes;
        repeat (3) put(3, 2, 8'hFF);
        put(3, 2, 8'h15);
        idle(4);
        chk("t3_writes", 32'(n_writes - n0), 32'd2);

        // Stalled RAM port: FIFO fills, two entries overflow
        do_reset();
        mif.mem_ready = 1'b0;
        for (int i = 1; i <= 6; i++) put(i, 1, i);
        idle(2);
        chk("t4_overflow", 32'(overflow_count), 32'd2);
        chk("t4_head_addr", 32'(mif.mem_addr), 32'd9);

        // Push arrives on the same edge as a pop from a full FIFO
        n0 = n_writes;
        put(7, 5, 8'hAA);
        mif.mem_ready = 1'b1;
        step();
        chk("t5_overflow", 32'(overflow_count), 32'd2);
        chk("t5_still_busy", 32'(mif.mem_wr_en), 32'd1);
        drain();
        chk("t5_writes", 32'(n_writes - n0), 32'd5);

        // Reset flushes queued entries and the dedup key
        do_reset();
        mif.mem_ready = 1'b0;
        put(2, 3, 8'h33);
        put(4, 1, 8'h44);
        put(6, 4, 8'h66);
        idle(2);
        do_reset();
        chk("t6_wr_en", 32'(mif.mem_wr_en), 32'd0);
        chk("t6_drop", 32'(drop_count), 32'd0);
        chk("t6_overflow", 32'(overflow_count), 32'd0);
        mif.mem_ready = 1'b1;
        n0 = n_writes;
        put(6, 4, 8'h66);
        idle(4);
        chk("t6_writes", 32'(n_writes - n0), 32'd1);

        // Randomised traffic with stalls, enables and occasional resets
        for (int c = 0; c < 1500; c++) begin
            wr_en         = ($urandom_range(0, 9) < 7);
            clk_en        = ($urandom_range(0, 9) < 9);
            x             = VGA_H_BITS'($urandom_range(0, 9));
            y             = VGA_V_BITS'($urandom_range(0, 7));
            pix           = BYTE_BITS'($urandom_range(0, 3));
            mif.mem_ready = ($urandom_range(0, 9) < 6);
            reset         = ($urandom_range(0, 299) == 0);
            step();
        end
        reset  = 1'b0;
        wr_en  = 1'b0;
        clk_en = 1'b1;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
